// File: rtl/lb_write_controller_if.sv
// Pixel-write and window-position bus between the line-buffer write sequencer
// and the tilebuffer / OCU side.
interface lb_write_controller_if #(
  parameter int N_I             = 128,
  parameter int COLADDRESSWIDTH = 5,
  parameter int ROWADDRESSWIDTH = 5
);
  logic                       wr_valid_i;
  logic                       wr_ready_o;
  logic                       wr_en_o;
  logic [COLADDRESSWIDTH-1:0] wr_col_o;
  logic                       shift_o;
  logic                       ready_o;
  logic                       ocu_ready_i;
  logic [COLADDRESSWIDTH-1:0] read_col_o;
  logic [ROWADDRESSWIDTH-1:0] read_row_o;
  // Active channel count of the running layer, forwarded to the consumers.
  logic [$clog2(N_I):0]       layer_ni;

  modport master (
    input  wr_valid_i, ocu_ready_i,
    output wr_ready_o, wr_en_o, wr_col_o, shift_o,
           ready_o, read_col_o, read_row_o, layer_ni
  );

  modport slave (
    output wr_valid_i, ocu_ready_i,
    input  wr_ready_o, wr_en_o, wr_col_o, shift_o,
           ready_o, read_col_o, read_row_o, layer_ni
  );
endinterface

// File: rtl/lb_write_controller.sv
// Write-side sequencer of the OCU line/tile buffer: column/shift generation for
// incoming pixels and window-centre stepping with SAME/VALID padding and stride.
package lb_write_controller_pkg;
  typedef enum logic {PAD_SAME = 1'b0, PAD_VALID = 1'b1} padding_type;
endpackage

module lb_write_controller
  import lb_write_controller_pkg::*;
#(
  parameter int N_I             = 128,
  parameter int K               = 3,
  parameter int IMAGEWIDTH      = 32,
  parameter int IMAGEHEIGHT     = 32,
  parameter int COLADDRESSWIDTH = $clog2(IMAGEWIDTH),
  parameter int ROWADDRESSWIDTH = $clog2(IMAGEHEIGHT)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         new_layer_i,
  input  logic [$clog2(K)-1:0]         layer_stride_width_i,
  input  logic [$clog2(K)-1:0]         layer_stride_height_i,
  input  padding_type                  layer_padding_type_i,
  input  logic [COLADDRESSWIDTH:0]     layer_imagewidth_i,
  input  logic [ROWADDRESSWIDTH:0]     layer_imageheight_i,
  input  logic [$clog2(N_I):0]         layer_ni_i,
  output logic                         layer_done_o,
  lb_write_controller_if.master        bus
);
  localparam int CW = COLADDRESSWIDTH;
  localparam int RW = ROWADDRESSWIDTH;
  localparam int SW = $clog2(K);
  localparam int P  = (K - 1) / 2;

  localparam logic [CW+1:0] P_COL = (CW+2)'(P);
  localparam logic [RW+1:0] P_ROW = (RW+2)'(P);
  localparam logic [CW:0]   K_COL = (CW+1)'(K);
  localparam logic [RW:0]   K_ROW = (RW+1)'(K);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]           state;
  logic [CW:0]          cfg_w;
  logic [RW:0]          cfg_h;
  logic [SW-1:0]        cfg_sw;
  logic [SW-1:0]        cfg_sh;
  logic                 cfg_valid;
  logic [$clog2(N_I):0] cfg_ni;

  logic [CW:0]          wcol;
  logic [RW:0]          rows_written;
  logic [RW:0]          c;
  logic [CW:0]          x;

  logic                 wr_active;
  logic                 wr_en;
  logic                 row_end;
  logic                 pos_hs;
  logic                 col_last;
  logic                 row_last;
  logic                 no_pos_in;
  logic [CW+1:0]        pad_col;
  logic [RW+1:0]        pad_row;
  logic [RW+1:0]        c_step;
  logic [RW+1:0]        rows_inc;
  logic [RW+1:0]        need_cur;
  logic [RW+1:0]        need_next;
  logic [CW:0]          x_start;

  function automatic logic [RW+1:0] need_of(input logic [RW+1:0] cc,
                                            input logic [RW:0]   h);
    logic [RW+1:0] lim;
    lim = cc + P_ROW + (RW+2)'(1);
    return (lim < (RW+2)'(h)) ? lim : (RW+2)'(h);
  endfunction

  // "Last centre" tests are done as "one more stride would overshoot", which
  // avoids dividing W/H by the stride to precompute xL/cL.
  always_comb begin
    wr_active = (state == ST_FILL) || (state == ST_DRAIN);
    wr_en     = wr_active & bus.wr_valid_i;
    row_end   = (wcol == (cfg_w - (CW+1)'(1)));
    pos_hs    = (state == ST_COMPUTE) & bus.ocu_ready_i;
    pad_col   = cfg_valid ? P_COL : '0;
    pad_row   = cfg_valid ? P_ROW : '0;
    col_last  = ((CW+2)'(x) + (CW+2)'(cfg_sw) + pad_col) >= (CW+2)'(cfg_w);
    c_step    = (RW+2)'(c) + (RW+2)'(cfg_sh);
    row_last  = (c_step + pad_row) >= (RW+2)'(cfg_h);
    rows_inc  = (RW+2)'(rows_written) + (RW+2)'(1);
    need_cur  = need_of((RW+2)'(c), cfg_h);
    need_next = need_of(c_step, cfg_h);
    x_start   = cfg_valid ? P_COL[CW:0] : '0;
    no_pos_in = (layer_padding_type_i == PAD_VALID) &&
                ((layer_imageheight_i < K_ROW) || (layer_imagewidth_i < K_COL));
  end

  assign bus.wr_ready_o = wr_active;
  assign bus.wr_en_o    = wr_en;
  assign bus.wr_col_o   = wr_active ? wcol[CW-1:0] : '0;
  assign bus.shift_o    = wr_en & row_end;
  assign bus.ready_o    = (state == ST_COMPUTE);
  assign bus.read_col_o = (state == ST_COMPUTE) ? x[CW-1:0] : '0;
  assign bus.read_row_o = (state == ST_COMPUTE) ? c[RW-1:0] : '0;
  assign bus.layer_ni   = cfg_ni;
  assign layer_done_o   = (state == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_sw       <= '0;
      cfg_sh       <= '0;
      cfg_valid    <= 1'b0;
      cfg_ni       <= '0;
      wcol         <= '0;
      rows_written <= '0;
      c            <= '0;
      x            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wcol         <= '0;
          rows_written <= '0;
          if (new_layer_i) begin
            cfg_w     <= layer_imagewidth_i;
            cfg_h     <= layer_imageheight_i;
            cfg_sw    <= (layer_stride_width_i == '0) ? SW'(1) : layer_stride_width_i;
            cfg_sh    <= (layer_stride_height_i == '0) ? SW'(1) : layer_stride_height_i;
            cfg_valid <= (layer_padding_type_i == PAD_VALID);
            cfg_ni    <= layer_ni_i;
            c         <= (layer_padding_type_i == PAD_VALID) ? P_ROW[RW:0] : '0;
            x         <= (layer_padding_type_i == PAD_VALID) ? P_COL[CW:0] : '0;
            // A VALID layer smaller than the kernel has no windows: just drain it.
            state     <= no_pos_in ? ST_DRAIN : ST_FILL;
          end
        end
        ST_FILL, ST_DRAIN: begin
          if (wr_en) begin
            if (row_end) begin
              wcol         <= '0;
              rows_written <= rows_inc[RW:0];
              if (state == ST_FILL && rows_inc >= need_cur)
                state <= ST_COMPUTE;
              else if (state == ST_DRAIN && rows_inc >= (RW+2)'(cfg_h))
                state <= ST_DONE;
            end else begin
              wcol <= wcol + (CW+1)'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (pos_hs) begin
            if (!col_last) begin
              x <= x + (CW+1)'(cfg_sw);
            end else begin
              x <= x_start;
              c <= c_step[RW:0];
              if (row_last)
                state <= (rows_written < cfg_h) ? ST_DRAIN : ST_DONE;
              else if ((RW+2)'(rows_written) < need_next)
                state <= ST_FILL;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lb_write_controller.sv
// Directed scoreboard bench for lb_write_controller: a reference sequence of
// writes/positions/done is queued per layer and matched against DUT activity.
module tb_lb_write_controller;
  import lb_write_controller_pkg::*;

  localparam int N_I = 128;
  localparam int K   = 3;
  localparam int IW  = 32;
  localparam int IH  = 32;
  localparam int CW  = $clog2(IW);
  localparam int RW  = $clog2(IH);
  localparam int SWB = $clog2(K);
  localparam int NIW = $clog2(N_I) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            new_layer = 1'b0;
  logic [SWB-1:0]  sw_in = '0;
  logic [SWB-1:0]  sh_in = '0;
  padding_type     pad_in = PAD_SAME;
  logic [CW:0]     w_in = '0;
  logic [RW:0]     h_in = '0;
  logic [NIW-1:0]  ni_in = '0;
  logic            layer_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] sb[$];

  lb_write_controller_if #(.N_I(N_I), .COLADDRESSWIDTH(CW), .ROWADDRESSWIDTH(RW)) bus ();

  lb_write_controller #(
    .N_I(N_I), .K(K), .IMAGEWIDTH(IW), .IMAGEHEIGHT(IH),
    .COLADDRESSWIDTH(CW), .ROWADDRESSWIDTH(RW)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .new_layer_i           (new_layer),
    .layer_stride_width_i  (sw_in),
    .layer_stride_height_i (sh_in),
    .layer_padding_type_i  (pad_in),
    .layer_imagewidth_i    (w_in),
    .layer_imageheight_i   (h_in),
    .layer_ni_i            (ni_in),
    .layer_done_o          (layer_done),
    .bus                   (bus)
  );

  always #5 clk = ~clk;

  // Event encoding: kind 0 = write (col, shift), 1 = position (row, col), 2 = done.
  function automatic logic [17:0] ev(input int kind, input int a, input int b);
    return {2'(kind), 8'(a), 8'(b)};
  endfunction

  function automatic logic [17:0] pop_exp();
    if (sb.size() == 0) return 18'h3FFFF;
    return sb.pop_front();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {bus.wr_ready_o, bus.wr_en_o, bus.wr_col_o, bus.shift_o, bus.ready_o,
                bus.read_col_o, bus.read_row_o, layer_done}, 32'd0);
  endtask

  task automatic push_row(input int w);
    for (int col = 0; col < w; col++)
      sb.push_back(ev(0, col, (col == w - 1) ? 1 : 0));
  endtask

  // Reference: for each centre row, top up rows to min(c+P+1,H), then sweep columns.
  task automatic build_model(input bit same, input int sw, input int sh, input int w, input int h);
    int s_w, s_h, p, c0, lim_r, lim_c, rows, need;
    s_w   = (sw == 0) ? 1 : sw;
    s_h   = (sh == 0) ? 1 : sh;
    p     = (K - 1) / 2;
    c0    = same ? 0 : p;
    lim_r = same ? h - 1 : h - 1 - p;
    lim_c = same ? w - 1 : w - 1 - p;
    rows  = 0;
    sb.delete();
    if (same || (h >= K && w >= K)) begin
      for (int c = c0; c <= lim_r; c += s_h) begin
        need = (c + p + 1 < h) ? c + p + 1 : h;
        while (rows < need) begin
          push_row(w);
          rows++;
        end
        for (int x = c0; x <= lim_c; x += s_w)
          sb.push_back(ev(1, c, x));
      end
    end
    while (rows < h) begin
      push_row(w);
      rows++;
    end
    sb.push_back(ev(2, 0, 0));
  endtask

  // vmode: 0 = wr_valid always, 1 = random gaps. omode: 0 = ocu always ready,
  // 1 = random, 2 = stall the first 5 presented cycles.
  task automatic applyStimulus(input string name, input bit same, input int sw, input int sh,
                               input int w, input int h, input int ni, input int vmode,
                               input int omode, input int glitch_at, input bit abort_on_pos);
    bit done_seen;
    int stalls;
    logic [17:0] exp;
    done_seen = 1'b0;
    stalls    = 0;
    build_model(same, sw, sh, w, h);
    $display("[TB] layer %s: %0d expected events", name, sb.size());
    @(negedge clk);
    pad_in    = same ? PAD_SAME : PAD_VALID;
    sw_in     = SWB'(sw);
    sh_in     = SWB'(sh);
    w_in      = (CW+1)'(w);
    h_in      = (RW+1)'(h);
    ni_in     = NIW'(ni);
    new_layer = 1'b1;
    for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
      @(negedge clk);
      if (cyc == glitch_at) begin
        new_layer = 1'b1;
        pad_in    = PAD_VALID;
        w_in      = (CW+1)'(2);
        ni_in     = NIW'(7);
      end else begin
        new_layer = 1'b0;
      end
      bus.wr_valid_i = (vmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
      #1;
      if (omode == 2 && bus.ready_o && stalls < 5) begin
        bus.ocu_ready_i = 1'b0;
        stalls++;
      end else if (omode == 1) begin
        bus.ocu_ready_i = ($urandom_range(0, 9) < 5);
      end else begin
        bus.ocu_ready_i = 1'b1;
      end
      #1;
      if (abort_on_pos && bus.ready_o) return;
      if (bus.ready_o && !bus.ocu_ready_i) begin
        check({name, "_hold_pos"}, ev(1, bus.read_row_o, bus.read_col_o),
              (sb.size() > 0) ? sb[0] : 18'h3FFFF);
        check({name, "_hold_wr_ready"}, bus.wr_ready_o, 32'd0);
      end
      if (bus.wr_ready_o && !bus.wr_valid_i && sb.size() > 0 && sb[0][17:16] == 2'd0)
        check({name, "_gap_col"}, bus.wr_col_o, sb[0][15:8]);
      if (bus.wr_en_o) begin
        exp = pop_exp();
        check({name, "_write"}, ev(0, bus.wr_col_o, bus.shift_o), exp);
      end
      if (bus.ready_o && bus.ocu_ready_i) begin
        exp = pop_exp();
        check({name, "_position"}, ev(1, bus.read_row_o, bus.read_col_o), exp);
      end
      if (layer_done) begin
        exp = pop_exp();
        check({name, "_done"}, ev(2, 0, 0), exp);
        check({name, "_layer_ni"}, bus.layer_ni, ni);
        done_seen = 1'b1;
      end
    end
    check({name, "_done_seen"}, done_seen, 1);
    checkOutput(name);
  endtask

  // After completion the block must sit idle with nothing left to deliver.
  task automatic checkOutput(input string name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      new_layer = 1'b0;
      #2;
      check_idle_outputs({name, "_idle_after"});
    end
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    bus.wr_valid_i  = 1'b0;
    bus.ocu_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_idle_outputs("reset_state");
    rst = 1'b0;

    applyStimulus("same_s1_4x4", 1'b1, 1, 1, 4, 4, 64, 0, 0, 3, 1'b0);
    applyStimulus("valid_s1_4x4", 1'b0, 1, 1, 4, 4, 128, 0, 0, -1, 1'b0);
    applyStimulus("same_s2_5x5", 1'b1, 2, 2, 5, 5, 17, 1, 0, -1, 1'b0);
    applyStimulus("valid_s2_6x6", 1'b0, 2, 2, 6, 6, 3, 1, 1, -1, 1'b0);
    applyStimulus("same_s0_stall", 1'b1, 0, 0, 4, 4, 9, 1, 2, -1, 1'b0);
    applyStimulus("valid_small", 1'b0, 1, 1, 5, 2, 1, 1, 0, -1, 1'b0);
    applyStimulus("same_w1", 1'b1, 1, 1, 1, 3, 2, 0, 1, -1, 1'b0);

    applyStimulus("abort", 1'b1, 1, 1, 4, 4, 5, 0, 0, -1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_valid_i  = 1'b1;
    bus.ocu_ready_i = 1'b1;
    @(negedge clk);
    #2;
    check_idle_outputs("reset_mid_compute");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      check_idle_outputs("idle_after_reset");
    end
    sb.delete();

    applyStimulus("valid_s1_5x5", 1'b0, 1, 1, 5, 5, 100, 1, 1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
